store_trace_monitor: RTL

- Synthesizable observer on the processor top's data-store bus (memwrite, dataadr, writedata, pc).
- Receives every store the core issues and buffers it in a trace FIFO, which is drained over a valid/ready port.
- Decides end-of-test: a store to the tohost address with the pass value gives PASS; any other value gives FAIL.
- Gives TIMEOUT if no tohost store arrives within a cycle budget.
- Sits beside the top in simulation and on FPGA, and drives done/pass/fail LEDs or bench checks.

---
 rtl/store_mon_pkg.sv | 15 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/store_trace_monitor.sv | 104 ++++++++++
 3 files changed

// File: rtl/store_mon_pkg.sv
// Shared types and default end-of-test constants for the store trace monitor.
package store_mon_pkg;

   typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } trace_entry_t;

   localparam logic [31:0] DefaultTohostAddr = 32'h0000_0054;
   localparam logic [31:0] DefaultPassValue  = 32'h0000_0007;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the extra pointer bit tells full from empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   assign data_o = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/store_trace_monitor.sv
// Observes core stores, buffers them in a trace FIFO and decides PASS/FAIL/TIMEOUT.
module store_trace_monitor
   import store_mon_pkg::*;
#(
   parameter int unsigned DEPTH          = 16,
   parameter logic [31:0] TOHOST_ADDR    = DefaultTohostAddr,
   parameter logic [31:0] PASS_VALUE     = DefaultPassValue,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwrite,
   input  logic [31:0]      dataadr,
   input  logic [31:0]      writedata,
   input  logic [31:0]      pc,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [31:0]      trace_pc,
   output logic [31:0]      trace_addr,
   output logic [31:0]      trace_data,
   output logic [CNT_W-1:0] store_count,
   output logic             overflow,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             ovf_q, ovf_d;

   trace_entry_t push_entry, head_entry;
   logic         fifo_full, fifo_empty;
   logic         in_run, store, tohost, pop;

   assign in_run = (state_q == StRun);
   assign store  = in_run & memwrite;
   assign tohost = store & (dataadr == TOHOST_ADDR);
   assign pop    = trace_valid & trace_ready;

   assign push_entry = '{pc: pc, addr: dataadr, data: writedata};

   sync_fifo #(
      .WIDTH ($bits(trace_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (store),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      cyc_d   = cyc_q;
      ovf_d   = ovf_q;
      if (in_run) cyc_d = cyc_q + CNT_W'(1);
      if (store) begin
         if (count_q != '1) count_d = count_q + CNT_W'(1);
         if (fifo_full && !pop) ovf_d = 1'b1;
      end
      // A tohost store on the budget's last edge takes precedence over the timeout.
      if (tohost) begin
         state_d = (writedata == PASS_VALUE) ? StPass : StFail;
      end else if (in_run && (TIMEOUT_CYCLES != 0) &&
                   (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
         state_d = StTimeout;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         count_q <= '0;
         cyc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         cyc_q   <= cyc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign trace_valid = ~fifo_empty;
   assign trace_pc    = head_entry.pc;
   assign trace_addr  = head_entry.addr;
   assign trace_data  = head_entry.data;
   assign store_count = count_q;
   assign overflow    = ovf_q;
   assign done        = (state_q != StRun);
   assign pass        = (state_q == StPass);
   assign fail        = (state_q == StFail) || (state_q == StTimeout);
   assign timeout     = (state_q == StTimeout);

endmodule
